// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame geometry and
// the keyboard command bytes used by the host and receiver blocks.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE
  } tx_state_e;

  localparam int FRAME_LEN = 11;
  // Bits the host shifts out after the start bit: 8 data, parity, stop.
  localparam int SHIFT_LEN = FRAME_LEN - 1;
  localparam int CNT_W     = 19;
  localparam int EDGE_W    = 4;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bus: byte request handshake plus open-drain
// line controls and raw line levels.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       kb_clk_in;
  logic       kb_data_in;
  logic       kb_clk_oe;
  logic       kb_data_oe;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data, tx_start, kb_clk_in, kb_data_in,
    input  kb_clk_oe, kb_data_oe, busy, done, err
  );

  modport slave (
    input  tx_data, tx_start, kb_clk_in, kb_data_in,
    output kb_clk_oe, kb_data_oe, busy, done, err
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter for a PS/2 line; a level
// change is accepted only after FILT_LEN consecutive differing samples.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk_25MHz,
  input  logic reset,
  input  logic line_i,
  output logic sync_o,
  output logic filt_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    sync_q;
  logic          filt_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      fall_q <= 1'b0;
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt_q <= sync_q[1];
        fall_q <= filt_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sync_o = sync_q[1];
  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, shift the
// frame on device clock falls, check the device ack, with an overall timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 2600,
  parameter int TIMEOUT_CYC = 375000,
  parameter int FILT_LEN    = 8
) (
  input  logic          clk_25MHz,
  input  logic          reset,
  ps2_host_tx_if.slave  bus
);

  tx_state_e              state_q;
  logic [SHIFT_LEN-1:0]   frame_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [EDGE_W-1:0]      edge_q;
  logic                   clk_oe_q, data_oe_q, busy_q, done_q, err_q;
  logic [1:0]             dsync_q;
  logic                   clk_sync, clk_filt, clk_fall;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .line_i    (bus.kb_clk_in),
    .sync_o    (clk_sync),
    .filt_o    (clk_filt),
    .fall_o    (clk_fall)
  );

  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) dsync_q <= 2'b11;
    else        dsync_q <= {dsync_q[0], bus.kb_data_in};
  end

  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      frame_q   <= '1;
      cnt_q     <= '0;
      edge_q    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q != ST_IDLE) cnt_q <= cnt_q + 1'b1;
      // Timeout spans the whole transfer and overrides every other state action.
      if (state_q != ST_IDLE && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        busy_q    <= 1'b0;
        err_q     <= 1'b1;
        state_q   <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            // done/err high means busy only just fell: that request is dropped.
            if (bus.tx_start && !done_q && !err_q) begin
              frame_q  <= {1'b1, odd_parity(bus.tx_data), bus.tx_data};
              cnt_q    <= '0;
              edge_q   <= '0;
              clk_oe_q <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
              data_oe_q <= 1'b1;
            end else if (cnt_q == CNT_W'(INHIBIT_CYC)) begin
              clk_oe_q <= 1'b0;
              state_q  <= ST_REQ;
            end
          end
          ST_REQ, ST_SHIFT: begin
            if (clk_fall) begin
              data_oe_q <= ~frame_q[0];
              frame_q   <= {1'b1, frame_q[SHIFT_LEN-1:1]};
              edge_q    <= edge_q + 1'b1;
              state_q   <= (edge_q == EDGE_W'(SHIFT_LEN - 1)) ? ST_ACK : ST_SHIFT;
            end
          end
          ST_ACK: begin
            if (clk_fall) begin
              if (!dsync_q[1]) begin
                state_q <= ST_RELEASE;
              end else begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
          ST_RELEASE: begin
            if (clk_filt && dsync_q[1]) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.kb_clk_oe  = clk_oe_q;
  assign bus.kb_data_oe = data_oe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

  logic unused_sync;
  assign unused_sync = clk_sync;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host and the received bits are compared with a reference frame per byte.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 40;
  localparam int TO  = 4000;
  localparam int FL  = 8;
  localparam int HP  = 50;

  logic clk_25MHz = 1'b0;
  logic reset     = 1'b0;
  logic dev_clk   = 1'b1;
  logic dev_data  = 1'b1;

  ps2_host_tx_if bus();

  assign bus.kb_clk_in  = dev_clk  & ~bus.kb_clk_oe;
  assign bus.kb_data_in = dev_data & ~bus.kb_data_oe;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FILT_LEN(FL)) dut (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .bus       (bus)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk_25MHz) cyc <= cyc + 1;

  int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   inh_start = 0, oe_len = 0, oe_ovl = 0, last_len = 0, last_ovl = 0;
  logic clk_oe_prev = 1'b0;

  always @(negedge clk_25MHz) begin
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
    if (bus.done && bus.err) both_cnt++;
    if (bus.kb_clk_oe) begin
      if (!clk_oe_prev) begin
        inh_start = cyc;
        oe_len = 0;
        oe_ovl = 0;
      end
      oe_len++;
      if (bus.kb_data_oe) oe_ovl++;
    end else if (clk_oe_prev) begin
      last_len = oe_len;
      last_ovl = oe_ovl;
    end
    clk_oe_prev = bus.kb_clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line bits as the device sees them: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_25MHz);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk_25MHz);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clk_25MHz);
    bus.tx_start = 1'b0;
  endtask

  task automatic dev_xfer(input logic [7:0] d, input bit ack, input bit glitch,
                          input int rst_edge, output logic [10:0] got, output bit aborted);
    int n = 0;
    got = '1;
    aborted = 1'b0;
    while (!(!bus.kb_clk_oe && bus.kb_data_oe) && n < INH + 200) begin
      @(negedge clk_25MHz);
      n++;
    end
    if (n >= INH + 200) begin
      chk("req_seen", 32'(bus.kb_data_oe & ~bus.kb_clk_oe), 32'd1);
      aborted = 1'b1;
      return;
    end
    wait_clks(30);
    got[0] = bus.kb_data_in;
    for (int e = 1; e <= 11; e++) begin
      if (glitch && e == 4) begin
        dev_clk = 1'b0;
        wait_clks(3);
        dev_clk = 1'b1;
        wait_clks(HP);
      end
      dev_clk = 1'b0;
      if (e == 11 && ack) dev_data = 1'b0;
      wait_clks(HP / 2);
      if (e == rst_edge) begin
        #3 reset = 1'b0;
        #1 chk("rst_async", {29'd0, bus.kb_clk_oe, bus.kb_data_oe, bus.busy}, 32'd0);
        wait_clks(5);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        wait_clks(5);
        reset = 1'b1;
        wait_clks(5);
        chk("rst_idle", {30'd0, bus.busy, bus.kb_clk_oe}, 32'd0);
        aborted = 1'b1;
        return;
      end
      wait_clks(HP - HP / 2);
      if (e == 6) chk("busy_mid", 32'(bus.busy), 32'd1);
      if (glitch && e == 3) begin
        bus.tx_data  = ~d;
        bus.tx_start = 1'b1;
        @(negedge clk_25MHz);
        bus.tx_start = 1'b0;
      end
      dev_clk = 1'b1;
      if (e <= 10) got[e] = bus.kb_data_in;
      if (e == 11) dev_data = 1'b1;
      wait_clks(HP);
    end
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input bit glitch,
                          input int rst_edge, input bit do_send);
    logic [10:0] got;
    bit aborted;
    int d0 = done_cnt, e0 = err_cnt;
    if (do_send) send(d);
    dev_xfer(d, ack, glitch, rst_edge, got, aborted);
    if (!aborted) begin
      wait_clks(100);
      chk($sformatf("frame_%02h", d), 32'(got), 32'(ref_frame(d)));
      chk("done_pulses", 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
      chk("err_pulses", 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
      chk("busy_after", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #3600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    wait_clks(5);
    chk("reset_outs", {27'd0, bus.kb_clk_oe, bus.kb_data_oe, bus.busy, bus.done, bus.err}, 32'd0);
    reset = 1'b1;
    wait_clks(5);
    chk("idle_outs", {29'd0, bus.kb_clk_oe, bus.kb_data_oe, bus.busy}, 32'd0);

    run_xfer(CMD_SET_LEDS, 1'b1, 1'b0, 0, 1'b1);
    chk("inhibit_len", 32'(last_len), 32'(INH + 1));
    chk("start_overlap", 32'(last_ovl), 32'd1);
    run_xfer(8'h00, 1'b1, 1'b0, 0, 1'b1);
    run_xfer(8'h07, 1'b1, 1'b0, 0, 1'b1);

    for (int i = 0; i < 5; i++)
      run_xfer(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 0, 1'b1);

    run_xfer(CMD_RESET, 1'b0, 1'b0, 0, 1'b1);
    run_xfer(8'($urandom), 1'b1, 1'b1, 0, 1'b1);

    // Device stays silent: the transfer must time out.
    send(8'($urandom));
    seen = 1'b0;
    n = 0;
    while (n < TO + 200) begin
      @(negedge clk_25MHz);
      n++;
      if (bus.err) begin
        seen = 1'b1;
        break;
      end
    end
    chk("timeout_seen", 32'(seen), 32'd1);
    chk("timeout_cycles", 32'(cyc - inh_start), 32'(TO));
    chk("timeout_oe", {30'd0, bus.kb_clk_oe, bus.kb_data_oe}, 32'd0);
    bus.tx_data  = 8'h5A;
    bus.tx_start = 1'b1;
    @(negedge clk_25MHz);
    chk("start_on_fall_ignored", 32'(bus.busy), 32'd0);
    @(negedge clk_25MHz);
    bus.tx_start = 1'b0;
    chk("start_next_cycle", 32'(bus.busy), 32'd1);
    run_xfer(8'h5A, 1'b1, 1'b0, 0, 1'b0);

    run_xfer(8'($urandom), 1'b1, 1'b0, 5, 1'b1);
    run_xfer(8'hF4, 1'b1, 1'b0, 0, 1'b1);

    chk("done_err_overlap", 32'(both_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
